// File: rtl/cordic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants for the fixed<->float front ends of the
//               CORDIC datapath. It holds the fixed-point geometry, the
//               IEEE-754 single-precision field layout and the converter
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int INTEGER_WIDTH    = 4;
    localparam int FRACTIONAL_WIDTH = 20;
    localparam int FLOAT_DATA_WIDTH = 32;
    localparam int FLOAT_BIAS       = 127;
    localparam int FLOAT_MANT_WIDTH = 23;

    localparam int FIXED_WIDTH      = INTEGER_WIDTH + FRACTIONAL_WIDTH;
    localparam int SHIFT_WIDTH      = 5;    // holds a normalize shift of 0..23

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } conv_state_e;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/fixed_to_float_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fixed_to_float_if
// Description : Valid/ready handshake bundle for the fixed-to-float converter.
//               Input side : in_valid, in_ready, fixed_in
//               Output side: out_valid, out_ready, float_out
//               master - the producer/consumer environment around the block
//               slave  - the converter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fixed_to_float_if #(
    parameter int FIXED_WIDTH = cordic_pkg::FIXED_WIDTH,
    parameter int FLOAT_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [FIXED_WIDTH-1:0] fixed_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [FLOAT_WIDTH-1:0] float_out;

    modport master (
        output in_valid, fixed_in, out_ready,
        input  in_ready, out_valid, float_out
    );

    modport slave (
        input  in_valid, fixed_in, out_ready,
        output in_ready, out_valid, float_out
    );

endinterface : fixed_to_float_if
`default_nettype wire

// File: rtl/fixed_to_float.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fixed_to_float
// Description : Converts a signed two's-complement fixed-point value
//               (INTEGER_WIDTH.FRACTIONAL_WIDTH, 24 bits total) into an
//               IEEE-754 single-precision float. Exact conversion: take the
//               magnitude, left-normalize one bit per cycle, then pack.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-low reset
//               clk_en - global enable; low freezes every register
//               bus    - fixed_to_float_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_float #(
    parameter int INTEGER_WIDTH    = cordic_pkg::INTEGER_WIDTH,
    parameter int FRACTIONAL_WIDTH = cordic_pkg::FRACTIONAL_WIDTH,
    parameter int FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    fixed_to_float_if.slave   bus
);

    import cordic_pkg::*;

    localparam int FIXED_W  = INTEGER_WIDTH + FRACTIONAL_WIDTH;
    localparam int MSB      = FIXED_W - 1;
    // Biased exponent when no normalize shift was needed (k = 0).
    localparam int EXP_BASE = FLOAT_BIAS + FLOAT_MANT_WIDTH - FRACTIONAL_WIDTH;

    // A 24-bit magnitude fits the 23-bit mantissa plus hidden bit exactly,
    // so no rounding logic exists; any other geometry is rejected.
    generate
        if (FIXED_W != 24 || FLOAT_DATA_WIDTH != 32) begin : g_width_check
            $error("fixed_to_float: INTEGER_WIDTH+FRACTIONAL_WIDTH must be 24 and FLOAT_DATA_WIDTH 32");
        end
    endgenerate

    conv_state_e                 state_q, state_d;
    logic [FIXED_W-1:0]          fixed_q, fixed_d;
    logic                        sign_q,  sign_d;
    logic [FIXED_W-1:0]          mag_q,   mag_d;
    logic [SHIFT_WIDTH-1:0]      k_q,     k_d;
    logic [FLOAT_DATA_WIDTH-1:0] float_q, float_d;

    logic [7:0]                  exp_w;

    assign exp_w = 8'(EXP_BASE - int'(k_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fixed_q <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            k_q     <= '0;
            float_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            fixed_q <= fixed_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            k_q     <= k_d;
            float_q <= float_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fixed_d = fixed_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        k_d     = k_q;
        float_d = float_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    fixed_d = bus.fixed_in;
                    state_d = ABS;
                end
            end
            ABS: begin
                sign_d  = fixed_q[MSB];
                // Negating the most-negative code wraps back to 0x800000,
                // which is the correct unsigned magnitude.
                mag_d   = fixed_q[MSB] ? -fixed_q : fixed_q;
                k_d     = '0;
                state_d = (fixed_q == '0) ? PACK : NORM;
            end
            NORM: begin
                if (mag_q[MSB]) begin
                    state_d = PACK;
                end else begin
                    mag_d = {mag_q[MSB-1:0], 1'b0};
                    k_d   = k_q + 5'd1;
                end
            end
            PACK: begin
                // Only a zero input reaches PACK with a zero magnitude;
                // it packs as +0.0 regardless of sign.
                if (mag_q == '0) begin
                    float_d = '0;
                end else begin
                    float_d = {sign_q, exp_w, mag_q[FLOAT_MANT_WIDTH-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.float_out = float_q;

endmodule : fixed_to_float
`default_nettype wire

// File: tb/tb_fixed_to_float.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_float
// Description : Directed self-checking bench for fixed_to_float. Drives
//               hand-computed vectors through the handshake and compares
//               result, latency, back-pressure hold, reset and stall
//               behaviour against constant expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    int n_checks = 0;
    int n_pass   = 0;

    fixed_to_float_if #(.FIXED_WIDTH(24), .FLOAT_WIDTH(32)) bus ();

    fixed_to_float dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one input, count edges from the accept edge until out_valid.
    // stall_at >= 0 drops clk_en after that many post-accept edges, for 4 edges.
    task automatic convert(input string tag, input logic [23:0] v,
                           input logic [31:0] ef, input int el, input int stall_at);
        int lat;
        lat = 0;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.fixed_in = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        while (lat < 100) begin
            if (lat == stall_at)     clk_en = 1'b0;
            if (lat == stall_at + 4) clk_en = 1'b1;
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        clk_en = 1'b1;
        check({tag, "_float"}, bus.float_out, ef);
        check({tag, "_lat"}, 32'(lat), 32'(el));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ovld_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        clk_en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.fixed_in  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_float",     bus.float_out,      32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;

        // Basic conversions: value, latency = 3 + k (2 for zero)
        convert("one",   24'h100000, 32'h3F80_0000, 6,  -1); consume("one");
        convert("neg8",  24'h800000, 32'hC100_0000, 3,  -1); consume("neg8");
        convert("neg15", 24'hE80000, 32'hBFC0_0000, 6,  -1); consume("neg15");
        convert("lsb",   24'h000001, 32'h3580_0000, 26, -1); consume("lsb");
        convert("zero",  24'h000000, 32'h0000_0000, 2,  -1); consume("zero");

        // Back-pressure: result held for 10 cycles, new input refused
        convert("half", 24'h080000, 32'h3F00_0000, 7, -1);
        bus.in_valid = 1'b1;
        bus.fixed_in = 24'h000000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_float", bus.float_out,      32'h3F00_0000);
            check("hold_ovld",  32'(bus.out_valid), 32'd1);
            check("hold_rdy",   32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 1'b0;
        consume("half");
        @(posedge clk);
        #1;
        check("idle_retain", bus.float_out, 32'h3F00_0000);

        // Asynchronous reset in the middle of normalization
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fixed_in = 24'h000001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_float",     bus.float_out,      32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        convert("post_rst", 24'h100000, 32'h3F80_0000, 6, -1); consume("post_rst");

        // clk_en stall of 4 cycles during NORM
        convert("stall", 24'h100000, 32'h3F80_0000, 10, 2); consume("stall");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fixed_to_float
`default_nettype wire

// File: doc/fixed_to_float.md
FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

Interface
REQ-001 Parameter INTEGER_WIDTH, default 4, integer bits of signed two's-complement fixed-point input.
REQ-002 Parameter FRACTIONAL_WIDTH, default 20, fractional bits of input.
REQ-003 Parameter FLOAT_DATA_WIDTH, default 32, IEEE-754 single-precision output width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 clk_en  input  1  when low, all registers hold, including state, counter and outputs.
REQ-007 in_valid  input  1  fixed_in valid.
REQ-008 in_ready  output  1  block can accept an input.
REQ-009 fixed_in  input  INTEGER_WIDTH+FRACTIONAL_WIDTH  signed fixed-point value.
REQ-010 out_valid  output  1  float_out valid.
REQ-011 out_ready  input  1  consumer accepts float_out.
REQ-012 float_out  output  FLOAT_DATA_WIDTH  IEEE-754 single result.

Function
REQ-013 Elaboration SHALL fail unless INTEGER_WIDTH+FRACTIONAL_WIDTH == 24, so conversion is exact with no rounding.
REQ-014 The state machine SHALL have states IDLE, ABS, NORM, PACK and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready&&clk_en, register fixed_in; go to ABS.
REQ-016 ABS: sign = fixed_in[23]; mag = |fixed_in| as 24-bit unsigned (0x800000 yields mag 0x800000); shift count k=0; go to PACK if mag==0, else NORM.
REQ-017 NORM: if mag[23]==1 go to PACK; else mag <= mag<<1 and k <= k+1 (one bit per cycle, k max 23).
REQ-018 PACK: float_out <= {sign, 8'(127+23-k-FRACTIONAL_WIDTH), mag[22:0]}; for zero input, float_out <= 0x00000000 (+0.0, sign forced 0); go to DONE.
REQ-019 DONE: out_valid=1; float_out stable; on out_ready go to IDLE with out_valid=0 the next cycle.
REQ-020 Handshake: float_out and out_valid SHALL NOT change while out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL be 1 only in IDLE; no new input is accepted until the current result is consumed.
REQ-022 Latency, counted from the accept edge to the edge raising out_valid, SHALL be 3+k cycles for nonzero input and 2 cycles for zero, for k in 0..23.
REQ-023 float_out SHALL retain its last value in IDLE; out_valid=0 outside DONE.
REQ-024 clk_en deasserted mid-conversion SHALL stall without corruption; latency extends by the stalled cycles.

Reset
REQ-025 rst low SHALL immediately force state=IDLE, in_ready=1, out_valid=0, float_out=0, mag=0, k=0, sign=0, regardless of clk or clk_en.
REQ-026 Reset mid-conversion SHALL discard the operation; the first accept after release behaves as from power-up.

Structure
REQ-027 The shared package cordic_pkg SHALL hold INTEGER_WIDTH, FRACTIONAL_WIDTH, FLOAT_DATA_WIDTH, FLOAT_BIAS=127, FLOAT_MANT_WIDTH=23 and the state encoding, shared with the float-to-fixed front end of CORDIC.
REQ-028 No sub-module is required: the absolute value, iterative normalizer and packer SHALL be a single FSM with one shift counter.

Verification
REQ-029 fixed_in=0x100000 (1.0) -> float_out=0x3F800000, out_valid 6 cycles after accept.
REQ-030 fixed_in=0x800000 (-8.0) -> float_out=0xC1000000, latency 3; fixed_in=0xE80000 (-1.5) -> 0xBFC00000, latency 6.
REQ-031 fixed_in=0x000001 (2^-20) -> float_out=0x35800000, latency 26; fixed_in=0x000000 -> 0x00000000, latency 2.
REQ-032 fixed_in=0x080000 (0.5) with out_ready held low 10 cycles -> float_out=0x3F000000 stable throughout, in_ready=0; IDLE reached one cycle after out_ready rises.
REQ-033 Start 0x000001, assert rst low mid-NORM -> outputs at reset values immediately; then 0x100000 -> 0x3F800000 with latency 6.
REQ-034 Start 0x100000, toggle clk_en low for 4 cycles during NORM -> 0x3F800000 with latency 10.
